// File: rtl/zle_b_dec.sv
// Zero run-length decoder: 8-bit ZLE tokens in, 7-bit symbols out; runs expand to N zeros. Optional ZLE_DEC_ERR_EN adds sticky o_err.
// Latency: a token accepted on edge k shows its first symbol in cycle k+1; one symbol per cycle.
// Backpressure: single registered output slot; o_ready low freezes the slot and run count and drops i_ready.
module zle_b_dec (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] i_d,
    input  logic       i_valid,
    output logic       i_ready,
    output logic [6:0] o_d,
    output logic       o_valid,
    input  logic       o_ready
`ifdef ZLE_DEC_ERR_EN
    ,
    output logic       o_err
`endif
);

    typedef enum logic {
        state_token = 1'b0,
        state_run   = 1'b1
    } state_t;

    state_t     state, state_n;
    logic [6:0] rem, rem_n;
    logic [6:0] o_d_n;
    logic       o_valid_n;
    logic       slot_free;
    logic       accept;
    logic       tok_run;
    logic [6:0] tok_val;
    logic       tok_drop;

    assign slot_free = !o_valid || o_ready;
    assign i_ready   = !reset && (state == state_token) && slot_free;
    assign accept    = i_valid && i_ready;
    assign tok_run   = i_d[7];
    assign tok_val   = i_d[6:0];

`ifdef ZLE_DEC_ERR_EN
    // 0x80 and 0x00 are both malformed: dropped and flagged
    logic err_n;
    assign tok_drop = (tok_val == 7'd0);
`else
    // only the empty run is dropped; literal 0x00 is a plain zero symbol
    assign tok_drop = tok_run && (tok_val == 7'd0);
`endif

    always_comb begin
        state_n   = state;
        rem_n     = rem;
        o_d_n     = o_d;
        o_valid_n = o_valid;
`ifdef ZLE_DEC_ERR_EN
        err_n     = o_err;
`endif
        if (slot_free) begin
            o_valid_n = 1'b0;
            if (state == state_run) begin
                if (rem != 7'd0) begin
                    o_d_n     = 7'd0;
                    o_valid_n = 1'b1;
                    rem_n     = rem - 7'd1;
                    if (rem == 7'd1) begin
                        state_n = state_token;
                    end
                end
            end else if (accept) begin
                if (tok_drop) begin
`ifdef ZLE_DEC_ERR_EN
                    err_n = 1'b1;
`endif
                end else if (tok_run) begin
                    o_d_n     = 7'd0;
                    o_valid_n = 1'b1;
                    rem_n     = tok_val - 7'd1;
                    if (tok_val != 7'd1) begin
                        state_n = state_run;
                    end
                end else begin
                    o_d_n     = tok_val;
                    o_valid_n = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= state_token;
            rem     <= 7'd0;
            o_d     <= 7'd0;
            o_valid <= 1'b0;
`ifdef ZLE_DEC_ERR_EN
            o_err   <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            rem     <= rem_n;
            o_d     <= o_d_n;
            o_valid <= o_valid_n;
`ifdef ZLE_DEC_ERR_EN
            o_err   <= err_n;
`endif
        end
    end

endmodule
